// File: rtl/cmac_tx_framer.sv
// cmac_tx_framer: frames a 512-bit stream into CMAC TX packets, each closed by a trailer beat.
// Optional feature: define CMAC_TX_FRAMER_TIMEOUT_EN to add idle-timeout frame close and timeout_cnt.
module cmac_tx_framer #(
    parameter int unsigned PKT_BEATS     = 16,
    parameter int unsigned FLUSH_TIMEOUT = 1024,
    parameter logic [31:0] TRL_MAGIC     = 32'h5A5A_A5A5
) (
    input  logic         gt_clk,
    input  logic         sys_reset,
    input  logic         in_tvalid,
    output logic         in_tready,
    input  logic [511:0] in_tdata,
    input  logic         in_tlast,
    output logic         tx_usr_axis_tvalid,
    input  logic         tx_usr_axis_tready,
    output logic [511:0] tx_usr_axis_tdata,
    output logic         tx_usr_axis_tlast,
    output logic [63:0]  tx_usr_axis_tkeep,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  timeout_cnt
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;
    state_t state, state_nx;
    logic [15:0] beat_cnt, beat_cnt_nx;
    logic [31:0] seq;
    logic fl_last, fl_cnt, fl_to, fl_last_nx, fl_cnt_nx, fl_to_nx;
    logic out_free, accept, cnt_hit, expire, load_trl, trl_done;
    logic [511:0] trailer;

    if (PKT_BEATS < 1 || PKT_BEATS > 65535 || FLUSH_TIMEOUT < 1) begin : g_bad_param
        $error("cmac_tx_framer: illegal PKT_BEATS or FLUSH_TIMEOUT");
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free  = !tx_usr_axis_tvalid || tx_usr_axis_tready;
    assign in_tready = (state != TRAILER) && out_free;
    assign accept    = in_tvalid && in_tready;
    assign cnt_hit   = (17'(beat_cnt) + 17'd1) == 17'(PKT_BEATS);
    assign load_trl  = (state == TRAILER) && out_free;
    assign trl_done  = tx_usr_axis_tvalid && tx_usr_axis_tready && tx_usr_axis_tlast;
    assign trailer   = {429'd0, fl_cnt, fl_to, fl_last, beat_cnt, seq, TRL_MAGIC};

`ifdef CMAC_TX_FRAMER_TIMEOUT_EN
    localparam int IW = $clog2(FLUSH_TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    // Expiry is flagged one cycle early so the trailer loads FLUSH_TIMEOUT+1 edges after the last beat.
    assign expire = (state == PAYLOAD) && !accept && (32'(idle_cnt) + 32'd1 == FLUSH_TIMEOUT);
    // Idle counter: counts PAYLOAD cycles without input, cleared by acceptance or outside PAYLOAD.
    always_ff @(posedge gt_clk) begin
        if (sys_reset || state != PAYLOAD || accept) idle_cnt <= '0;
        else idle_cnt <= idle_cnt + 1'b1;
    end
    // Saturating count of timeout-closed frames, bumped when CMAC takes their trailer.
    always_ff @(posedge gt_clk) begin
        if (sys_reset) timeout_cnt <= '0;
        else if (trl_done && tx_usr_axis_tdata[81] && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
    end
`else
    assign expire      = 1'b0;
    assign timeout_cnt = '0;
`endif

    // Next state, per-frame beat count and close-reason flags.
    always_comb begin
        state_nx    = state;
        beat_cnt_nx = beat_cnt;
        fl_last_nx  = fl_last;
        fl_cnt_nx   = fl_cnt;
        fl_to_nx    = fl_to;
        if (accept) begin
            beat_cnt_nx = beat_cnt + 16'd1;
            state_nx    = (cnt_hit || in_tlast) ? TRAILER : PAYLOAD;
            fl_last_nx  = in_tlast;
            fl_cnt_nx   = cnt_hit;
            fl_to_nx    = 1'b0;
        end else if (expire) begin
            state_nx   = TRAILER;
            fl_last_nx = 1'b0;
            fl_cnt_nx  = 1'b0;
            fl_to_nx   = 1'b1;
        end else if (load_trl) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
        end
    end

    // State register and frame bookkeeping.
    always_ff @(posedge gt_clk) begin
        if (sys_reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            fl_last  <= 1'b0;
            fl_cnt   <= 1'b0;
            fl_to    <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            fl_last  <= fl_last_nx;
            fl_cnt   <= fl_cnt_nx;
            fl_to    <= fl_to_nx;
        end
    end

    // Single-stage output register; holds while CMAC stalls a valid beat.
    always_ff @(posedge gt_clk) begin
        if (sys_reset) begin
            tx_usr_axis_tvalid <= 1'b0;
            tx_usr_axis_tdata  <= '0;
            tx_usr_axis_tlast  <= 1'b0;
            tx_usr_axis_tkeep  <= '0;
        end else if (out_free) begin
            tx_usr_axis_tvalid <= accept || load_trl;
            if (accept) begin
                tx_usr_axis_tdata <= in_tdata;
                tx_usr_axis_tlast <= 1'b0;
                tx_usr_axis_tkeep <= '1;
            end else if (load_trl) begin
                tx_usr_axis_tdata <= trailer;
                tx_usr_axis_tlast <= 1'b1;
                tx_usr_axis_tkeep <= 64'h0000_0000_0000_FFFF;
            end
        end
    end

    // Sequence number and frame counter advance when CMAC accepts a trailer.
    always_ff @(posedge gt_clk) begin
        if (sys_reset) begin
            seq       <= '0;
            frame_cnt <= '0;
        end else if (trl_done) begin
            seq       <= seq + 32'd1;
            frame_cnt <= frame_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_cmac_tx_framer.sv
// tb_cmac_tx_framer: directed self-checking bench for cmac_tx_framer.
module tb_cmac_tx_framer;
`ifdef CMAC_TX_FRAMER_TIMEOUT_EN
    localparam int T = 1024;
`endif
    typedef logic [576:0] beat_t;
    logic clk = 0, rst = 1;
    logic in_tvalid = 0, in_tready, in_tlast = 0;
    logic [511:0] in_tdata = '0;
    logic tv, tr = 1, tl;
    logic [511:0] td;
    logic [63:0] tk;
    logic [31:0] frame_cnt;
    logic [15:0] timeout_cnt;
    int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0, trl_cyc = 0, stalls = 0, stab_err = 0;
    int unsigned bid = 1;
    bit done = 0;
    logic prev_hold = 0;
    beat_t prev_beat = '0;
    beat_t got[$], exp_q[$];

    cmac_tx_framer dut (
        .gt_clk(clk), .sys_reset(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
        .tx_usr_axis_tvalid(tv), .tx_usr_axis_tready(tr), .tx_usr_axis_tdata(td),
        .tx_usr_axis_tlast(tl), .tx_usr_axis_tkeep(tk),
        .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // Capture accepted output beats, input acceptance times, stalls and AXIS stability.
    always @(posedge clk) begin
        cyc++;
        if (!rst && tv && tr) begin
            got.push_back({tl, tk, td});
            if (tl) trl_cyc = cyc;
        end
        if (!rst && in_tvalid && in_tready) acc_cyc = cyc;
        if (!rst && in_tvalid && !in_tready) stalls++;
        if (!rst && prev_hold && (!tv || {tl, tk, td} !== prev_beat)) stab_err++;
        prev_hold = !rst && tv && !tr;
        prev_beat = {tl, tk, td};
    end

    function automatic beat_t pay(input int unsigned id);
        return {1'b0, {64{1'b1}}, {16{id}}};
    endfunction

    // f = {closed-by-count, closed-by-timeout, closed-by-tlast}
    function automatic beat_t trl(input logic [31:0] s, input logic [15:0] c, input logic [2:0] f);
        beat_t b = '0;
        b[576] = 1'b1;
        b[575:512] = 64'h0000_0000_0000_FFFF;
        b[31:0] = 32'h5A5A_A5A5;
        b[63:32] = s;
        b[79:64] = c;
        b[82:80] = f;
        return b;
    endfunction

    task automatic send(input int n, input logic last_on_final);
        for (int i = 1; i <= n; i++) begin
            int w = 0;
            in_tvalid = 1;
            in_tdata = {16{bid}};
            in_tlast = last_on_final && i == n;
            exp_q.push_back(pay(bid));
            bid++;
            @(negedge clk);
            while (!in_tready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_wait: in_tready stuck at 0, required 1");
            end
            @(posedge clk);
            #1;
        end
        in_tvalid = 0;
        in_tlast = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({tv, tl} !== 2'b00) begin n_bad++; $display("FAIL rst_valid_last: got %b, required 00", {tv, tl}); end
        n_cmp++; if (td !== '0) begin n_bad++; $display("FAIL rst_tdata: got %h, required 0", td[95:0]); end
        n_cmp++; if (tk !== '0) begin n_bad++; $display("FAIL rst_tkeep: got %h, required 0", tk); end
        n_cmp++; if (frame_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
        n_cmp++; if (timeout_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_timeout_cnt: got %0d, required 0", timeout_cnt); end
        n_cmp++; if (in_tready !== 1'b1) begin n_bad++; $display("FAIL rst_in_tready: got %b, required 1", in_tready); end
        rst = 0;
    endtask

    task automatic test_continuous;
        got.delete(); exp_q.delete(); stalls = 0;
        send(16, 0);
        exp_q.push_back(trl(0, 16, 3'b100));
        send(16, 0);
        exp_q.push_back(trl(1, 16, 3'b100));
        n_cmp++; if (in_tready !== 1'b0) begin n_bad++; $display("FAIL cont_trailer_stall: in_tready %b, required 0", in_tready); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (stalls !== 1) begin n_bad++; $display("FAIL cont_stalls: got %0d, required 1", stalls); end
        n_cmp++; if (frame_cnt !== 32'd2) begin n_bad++; $display("FAIL cont_frame_cnt: got %0d, required 2", frame_cnt); end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL cont_len: got %0d beats, required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL cont_beat%0d: got %h/%h, required %h/%h", i, got[i][576:512], got[i][95:0], exp_q[i][576:512], exp_q[i][95:0]); end
        end
    endtask

    task automatic test_tlast;
        got.delete(); exp_q.delete();
        send(5, 1);
        exp_q.push_back(trl(2, 5, 3'b001));
        send(16, 1);
        exp_q.push_back(trl(3, 16, 3'b101));
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (frame_cnt !== 32'd4) begin n_bad++; $display("FAIL tlast_frame_cnt: got %0d, required 4", frame_cnt); end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL tlast_len: got %0d beats, required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL tlast_beat%0d: got %h/%h, required %h/%h", i, got[i][576:512], got[i][95:0], exp_q[i][576:512], exp_q[i][95:0]); end
        end
    endtask

    task automatic test_timeout;
        got.delete(); exp_q.delete();
        send(3, 0);
`ifdef CMAC_TX_FRAMER_TIMEOUT_EN
        exp_q.push_back(trl(4, 3, 3'b010));
        for (int w = 0; w < 1200 && got.size() < 4; w++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (trl_cyc - acc_cyc != T + 2) begin n_bad++; $display("FAIL to_latency: trailer taken %0d edges after beat 3, required %0d", trl_cyc - acc_cyc, T + 2); end
        n_cmp++; if (timeout_cnt !== 16'd1) begin n_bad++; $display("FAIL to_timeout_cnt: got %0d, required 1", timeout_cnt); end
`else
        repeat (5000) @(posedge clk);
        #1;
        n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL to_no_trailer: got %0d beats, required 3", got.size()); end
        n_cmp++; if (in_tready !== 1'b1) begin n_bad++; $display("FAIL to_in_tready: got %b, required 1", in_tready); end
        n_cmp++; if (timeout_cnt !== 16'd0) begin n_bad++; $display("FAIL to_timeout_cnt: got %0d, required 0", timeout_cnt); end
        send(1, 1);
        exp_q.push_back(trl(4, 4, 3'b001));
        repeat (5) @(posedge clk);
        #1;
`endif
        n_cmp++; if (frame_cnt !== 32'd5) begin n_bad++; $display("FAIL to_frame_cnt: got %0d, required 5", frame_cnt); end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL to_len: got %0d beats, required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL to_beat%0d: got %h/%h, required %h/%h", i, got[i][576:512], got[i][95:0], exp_q[i][576:512], exp_q[i][95:0]); end
        end
    endtask

    task automatic test_backpressure;
        got.delete(); exp_q.delete(); stab_err = 0; done = 0;
        fork
            begin
                send(16, 0);
                exp_q.push_back(trl(5, 16, 3'b100));
                send(5, 1);
                exp_q.push_back(trl(6, 5, 3'b001));
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                tr = 1'($urandom_range(0, 1));
            end
        join
        tr = 1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stability: %0d unstable stalled beats, required 0", stab_err); end
        n_cmp++; if (frame_cnt !== 32'd7) begin n_bad++; $display("FAIL bp_frame_cnt: got %0d, required 7", frame_cnt); end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_len: got %0d beats, required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat%0d: got %h/%h, required %h/%h", i, got[i][576:512], got[i][95:0], exp_q[i][576:512], exp_q[i][95:0]); end
        end
    endtask

    task automatic test_reset_midframe;
        got.delete(); exp_q.delete();
        send(6, 0);
        in_tvalid = 1;
        in_tdata = {16{bid}};
        rst = 1;
        @(posedge clk);
        #1;
        n_cmp++; if ({tv, tl} !== 2'b00) begin n_bad++; $display("FAIL mid_valid_last: got %b, required 00", {tv, tl}); end
        n_cmp++; if (td !== '0 || tk !== '0) begin n_bad++; $display("FAIL mid_data_keep: got %h/%h, required 0/0", td[95:0], tk); end
        n_cmp++; if (frame_cnt !== 32'd0 || timeout_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_counters: got %0d/%0d, required 0/0", frame_cnt, timeout_cnt); end
        rst = 0;
        in_tvalid = 0;
        bid++;
        got.delete(); exp_q.delete();
        send(1, 1);
        exp_q.push_back(trl(0, 1, 3'b001));
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (frame_cnt !== 32'd1) begin n_bad++; $display("FAIL mid_frame_cnt: got %0d, required 1", frame_cnt); end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL mid_len: got %0d beats, required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_beat%0d: got %h/%h, required %h/%h", i, got[i][576:512], got[i][95:0], exp_q[i][576:512], exp_q[i][95:0]); end
        end
    endtask

    initial begin
        test_reset;
        test_continuous;
        test_tlast;
        test_timeout;
        test_backpressure;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
